// File: rtl/cnn_maxpool_rx.sv
// rtl/cnn_maxpool_rx.sv - 2x2 stride-2 max pooling receiver for the conv core output stream
module cnn_maxpool_rx #(
    parameter int CO   = 3,
    parameter int I_BW = 19,
    parameter int OX   = 24,
    parameter int OY   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_in_valid,
    input  logic [CO*I_BW-1:0]   i_in_fmap,
    output logic                 o_ot_valid,
    output logic [CO*I_BW-1:0]   o_ot_fmap,
    output logic                 o_ot_last
);

    localparam int DW = CO * I_BW;
    localparam int CW = (OX > 1) ? $clog2(OX) : 1;
    localparam int RW = (OY > 1) ? $clog2(OY) : 1;
    localparam int PW = (OX > 2) ? $clog2(OX / 2) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OY - 1);

    // position inside the incoming frame
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // left pixel of the current horizontal pair
    logic [DW-1:0] r_hold;

    // pair maxima of the last even row, one entry per pooled column
    logic [DW-1:0] r_rowbuf [0:OX/2-1];

    logic          r_ot_valid;
    logic          r_ot_last;
    logic [DW-1:0] r_ot_fmap;

    logic [PW-1:0] w_pidx;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] w_pair_max;
    logic [DW-1:0] w_win_max;
    logic          w_col_last;
    logic          w_row_last;

    assign w_pidx     = PW'(r_col >> 1);
    assign w_rd       = r_rowbuf[w_pidx];
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    // per-channel unsigned maxima; channels never interact
    for (genvar k = 0; k < CO; k++) begin : g_ch
        logic [I_BW-1:0] w_h;
        logic [I_BW-1:0] w_i;
        logic [I_BW-1:0] w_b;
        logic [I_BW-1:0] w_p;
        assign w_h = r_hold[k*I_BW +: I_BW];
        assign w_i = i_in_fmap[k*I_BW +: I_BW];
        assign w_b = w_rd[k*I_BW +: I_BW];
        assign w_p = (w_i > w_h) ? w_i : w_h;
        assign w_pair_max[k*I_BW +: I_BW] = w_p;
        assign w_win_max[k*I_BW +: I_BW]  = (w_b > w_p) ? w_b : w_p;
    end

    // counters, pair hold and pooled output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hold     <= '0;
            r_ot_valid <= 1'b0;
            r_ot_last  <= 1'b0;
            r_ot_fmap  <= '0;
        end else begin
            r_ot_valid <= 1'b0;
            r_ot_last  <= 1'b0;
            if (i_in_valid) begin
                if (!r_col[0]) begin
                    r_hold <= i_in_fmap;
                end else if (r_row[0]) begin
                    r_ot_fmap  <= w_win_max;
                    r_ot_valid <= 1'b1;
                    r_ot_last  <= w_col_last && w_row_last;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // row buffer is always written on an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (!reset && i_in_valid && r_col[0] && !r_row[0]) begin
            r_rowbuf[w_pidx] <= w_pair_max;
        end
    end

    assign o_ot_valid = r_ot_valid;
    assign o_ot_last  = r_ot_last;
    assign o_ot_fmap  = r_ot_fmap;

endmodule

// File: tb/tb_cnn_maxpool_rx.sv
// tb/tb_cnn_maxpool_rx.sv - self-checking bench for cnn_maxpool_rx
module tb_cnn_maxpool_rx;

    localparam int CO   = 3;
    localparam int I_BW = 19;
    localparam int OX   = 24;
    localparam int OY   = 24;
    localparam int DW   = CO * I_BW;

    logic          clk;
    logic          reset;
    logic          i_in_valid;
    logic [DW-1:0] i_in_fmap;
    logic          o_ot_valid;
    logic [DW-1:0] o_ot_fmap;
    logic          o_ot_last;

    cnn_maxpool_rx #(.CO(CO), .I_BW(I_BW), .OX(OX), .OY(OY)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_in_valid (i_in_valid),
        .i_in_fmap  (i_in_fmap),
        .o_ot_valid (o_ot_valid),
        .o_ot_fmap  (o_ot_fmap),
        .o_ot_last  (o_ot_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int nframes;
        int gap_pct;
        int rst_after;
        int exp_cnt;
        int exp_lastcnt;
        int chkvals;
        int f0, f1, f2;
        int l0, l1, l2;
        int sec_idx;
        int sec0;
    } vec_t;

    typedef struct {
        logic [DW-1:0] fmap;
        logic          last;
    } exp_t;

    int            n_chk;
    int            n_err;
    logic [DW-1:0] fr [0:OX*OY-1];
    exp_t          exp_q[$];
    logic          exp_pulse;
    logic          mon_en;
    int            n_out;
    int            n_last;
    int            cur_sec;
    logic [DW-1:0] out_first;
    logic [DW-1:0] out_lastv;
    logic [DW-1:0] out_sec;
    vec_t          vecs [0:7];

    task automatic check(input string name, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] p;
        p = '0;
        p[0*I_BW +: I_BW] = I_BW'(a);
        p[1*I_BW +: I_BW] = I_BW'(b);
        p[2*I_BW +: I_BW] = I_BW'(c);
        return p;
    endfunction

    // reference: each pixel of the frame computed directly from its pattern rule
    task automatic gen_frame(input int kind, input int f);
        for (int r = 0; r < OY; r++) begin
            for (int c = 0; c < OX; c++) begin
                for (int k = 0; k < CO; k++) begin
                    int v;
                    int w;
                    int pos;
                    case (kind)
                        0: v = r*24 + c + k*1000 + 5*f;
                        1: begin
                            w   = (r/2)*(OX/2) + (c/2);
                            pos = (r%2)*2 + (c%2);
                            v   = (pos == w%4) ? 100 : 0;
                        end
                        2: v = 7;
                        3: v = (k == 2) ? 524287 : 0;
                        default: v = int'($urandom_range(524287));
                    endcase
                    fr[r*OX+c][k*I_BW +: I_BW] = I_BW'(v);
                end
            end
        end
    endtask

    // reference: max over the 2x2 window whose bottom-right pixel is (r,c)
    function automatic logic [DW-1:0] win_max(input int r, input int c);
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k < CO; k++) begin
            logic [I_BW-1:0] m;
            m = 0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++)
                    if (fr[(r-dr)*OX + (c-dc)][k*I_BW +: I_BW] > m)
                        m = fr[(r-dr)*OX + (c-dc)][k*I_BW +: I_BW];
            res[k*I_BW +: I_BW] = m;
        end
        return res;
    endfunction

    task automatic drive_idle();
        @(negedge clk);
        i_in_valid = 1'b0;
        i_in_fmap  = DW'({$urandom(), $urandom()});
        exp_pulse  = 1'b0;
    endtask

    task automatic drive_pix(input int r, input int c);
        exp_t e;
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_fmap  = fr[r*OX+c];
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.fmap = win_max(r, c);
            e.last = (r == OY-1) && (c == OX-1);
            exp_q.push_back(e);
            exp_pulse = 1'b1;
        end else begin
            exp_pulse = 1'b0;
        end
    endtask

    task automatic drive_frame(input int kind, input int f, input int gap, input int max_beats);
        int beats;
        beats = 0;
        gen_frame(kind, f);
        for (int r = 0; r < OY; r++) begin
            for (int c = 0; c < OX; c++) begin
                if (beats < max_beats) begin
                    if (gap > 0 && int'($urandom_range(99)) < gap) drive_idle();
                    drive_pix(r, c);
                    beats++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        i_in_valid = 1'b0;
        exp_pulse  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("rst_fmap", o_ot_fmap, 0);
        check("rst_last", o_ot_last, 0);
        n_out  = 0;
        n_last = 0;
    endtask

    // a pulse is required exactly one cycle after each odd-row/odd-col beat
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            check("valid_timing", o_ot_valid, exp_pulse);
            if (exp_pulse) begin
                if (exp_q.size() == 0) begin
                    check("exp_queue_nonempty", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (o_ot_valid) begin
                        check("pool_fmap", o_ot_fmap, e.fmap);
                        check("pool_last", o_ot_last, e.last);
                        if (n_out == 0) out_first = o_ot_fmap;
                        if (n_out == cur_sec) out_sec = o_ot_fmap;
                        out_lastv = o_ot_fmap;
                        if (o_ot_last) n_last++;
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        mon_en     = 1'b0;
        exp_pulse  = 1'b0;
        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        n_out      = 0;
        n_last     = 0;
        cur_sec    = -1;
        out_first  = '0;
        out_lastv  = '0;
        out_sec    = '0;

        //          kind frm gap rst  cnt last chk f0   f1    f2      l0   l1    l2      sec  sec0
        vecs[0] = '{0,   1,  0,  0,   144, 1,  1,  25,  1025, 2025,   575, 1575, 2575,   0,   0};
        vecs[1] = '{1,   1,  0,  0,   144, 1,  1,  100, 100,  100,    100, 100,  100,    0,   0};
        vecs[2] = '{2,   1,  0,  0,   144, 1,  1,  7,   7,    7,      7,   7,    7,      0,   0};
        vecs[3] = '{0,   1,  50, 0,   144, 1,  1,  25,  1025, 2025,   575, 1575, 2575,   0,   0};
        vecs[4] = '{0,   2,  0,  0,   288, 2,  1,  25,  1025, 2025,   580, 1580, 2580,   144, 30};
        vecs[5] = '{0,   1,  0,  300, 144, 1,  1,  25,  1025, 2025,   575, 1575, 2575,   0,   0};
        vecs[6] = '{3,   1,  0,  0,   144, 1,  1,  0,   0,    524287, 0,   0,    524287, 0,   0};
        vecs[7] = '{4,   2,  30, 0,   288, 2,  0,  0,   0,    0,      0,   0,    0,      0,   0};

        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        check("init_valid", o_ot_valid, 0);
        check("init_fmap", o_ot_fmap, 0);
        check("init_last", o_ot_last, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v       = vecs[i];
            cur_sec = (v.sec_idx > 0) ? v.sec_idx : -1;
            n_out   = 0;
            n_last  = 0;
            if (v.rst_after > 0) begin
                drive_frame(v.kind, 0, v.gap_pct, v.rst_after);
                do_reset();
                drive_frame(v.kind, 0, v.gap_pct, OX*OY);
            end else begin
                for (int f = 0; f < v.nframes; f++)
                    drive_frame(v.kind, f, v.gap_pct, OX*OY);
            end
            repeat (3) drive_idle();
            check($sformatf("v%0d_count", i), n_out, v.exp_cnt);
            check($sformatf("v%0d_lastcount", i), n_last, v.exp_lastcnt);
            check($sformatf("v%0d_queue_drained", i), exp_q.size(), 0);
            if (v.chkvals != 0) begin
                check($sformatf("v%0d_first", i), out_first, pack3(v.f0, v.f1, v.f2));
                check($sformatf("v%0d_final", i), out_lastv, pack3(v.l0, v.l1, v.l2));
            end
            if (v.sec_idx > 0)
                check($sformatf("v%0d_frame2_first_ch0", i), out_sec[0 +: I_BW], v.sec0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
